// File: rtl/larpix_rx_packet_sorter.sv
// ---------------------------------------------------------------------------
// larpix_rx_packet_sorter
//
// Sits directly behind uart_rx_fpga on the receive FPGA. Pulls each 64-bit
// LArPix packet out of the UART using the unload handshake, checks its odd
// parity, classifies it by the declare bits, optionally filters it by chip
// ID, and queues accepted packets in a first-word-fall-through FIFO for the
// readout logic. Per-type saturating tallies are kept alongside.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   rx_data           word presented by uart_rx_fpga
//   rx_empty          uart_rx_fpga empty flag (low = word waiting)
//   uld_rx_data       one-cycle unload strobe back to uart_rx_fpga
//   filter_en         enable chip-ID filtering
//   chip_id_filter    chip ID to keep; GLOBAL_ID keeps every chip
//   cnt_clear         synchronous clear of every tally
//   out_data          head-of-FIFO packet (0 while the FIFO is empty)
//   out_parity_err    head packet failed parity
//   out_valid         FIFO holds at least one packet
//   out_ready         consumer pop, taken when out_valid & out_ready
//   fifo_level        current FIFO occupancy
//   cnt_*             saturating per-type tallies
// ---------------------------------------------------------------------------
module larpix_rx_packet_sorter #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GLOBAL_ID  = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              rx_data,
  input  logic                          rx_empty,
  output logic                          uld_rx_data,
  input  logic                          filter_en,
  input  logic [7:0]                    chip_id_filter,
  input  logic                          cnt_clear,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_parity_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          cnt_data,
  output logic [CNT_WIDTH-1:0]          cnt_cfg_wr,
  output logic [CNT_WIDTH-1:0]          cnt_cfg_rd,
  output logic [CNT_WIDTH-1:0]          cnt_bad_decl,
  output logic [CNT_WIDTH-1:0]          cnt_parity_err,
  output logic [CNT_WIDTH-1:0]          cnt_filtered
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    UNLOAD,
    CAPTURE,
    CLASSIFY
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              armed;
  logic              start_unload;
  logic [WIDTH-1:0]  pkt;

  logic              par_err;
  logic [1:0]        declare;
  logic [7:0]        chip_id;
  logic              bad_decl;
  logic              filter_hit;
  logic              in_classify;
  logic              push;
  logic              pop;

  logic              inc_data;
  logic              inc_cfg_wr;
  logic              inc_cfg_rd;
  logic              inc_bad_decl;
  logic              inc_parity_err;
  logic              inc_filtered;

  logic [WIDTH:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [WIDTH:0]    head;

  // ------------------------------------------------------------------------
  // FSM state register.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic. Leaving IDLE needs a word waiting, the arm flag, and a
  // free FIFO slot; checking the level here reserves the slot for this
  // packet, so the push in CLASSIFY can never overflow. The remaining states
  // simply walk forward one cycle each.
  // ------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    start_unload = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_empty && armed && (level < LVL_W'(FIFO_DEPTH))) begin
          state_next   = UNLOAD;
          start_unload = 1'b1;
        end
      end
      UNLOAD:   state_next = CAPTURE;
      CAPTURE:  state_next = CLASSIFY;
      CLASSIFY: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Unload strobe is registered so it is high for exactly the UNLOAD cycle
  // and glitch-free toward the UART.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      uld_rx_data <= 1'b0;
    end else begin
      uld_rx_data <= start_unload;
    end
  end

  // ------------------------------------------------------------------------
  // Arm flag: the UART needs a cycle or so to raise its empty flag after an
  // unload. Requiring the flag to be seen high before the next unload stops
  // the same word from being pulled twice.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1;
    end else if (rx_empty) begin
      armed <= 1'b1;
    end else if (start_unload) begin
      armed <= 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // Packet capture register, loaded in CAPTURE while the UART still holds
  // the unloaded word on rx_data.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt <= '0;
    end else if (state == CAPTURE) begin
      pkt <= rx_data;
    end
  end

  // ------------------------------------------------------------------------
  // Classification of the captured packet. Parity is odd over the whole
  // word, so the top bit must be the inverted XOR of the rest. A bad-parity
  // packet still goes through the declare and filter checks; a declare of 0
  // is never pushed; filtered packets are dropped but counted.
  // ------------------------------------------------------------------------
  always_comb begin
    par_err     = (pkt[WIDTH-1] != ~^pkt[WIDTH-2:0]);
    declare     = pkt[1:0];
    chip_id     = pkt[9:2];
    in_classify = (state == CLASSIFY);
    bad_decl    = (declare == 2'b00);
    filter_hit  = filter_en &&
                  (chip_id_filter != 8'(GLOBAL_ID)) &&
                  (chip_id != chip_id_filter);
    push        = in_classify && !bad_decl && !filter_hit;

    inc_parity_err = in_classify && par_err;
    inc_bad_decl   = in_classify && bad_decl;
    inc_filtered   = in_classify && !bad_decl && filter_hit;
    inc_data       = push && (declare == 2'b01);
    inc_cfg_wr     = push && (declare == 2'b10);
    inc_cfg_rd     = push && (declare == 2'b11);
  end

  // ------------------------------------------------------------------------
  // FIFO storage. Each entry carries the parity-error flag above the packet.
  // No reset is needed on the array: the output is masked while empty.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {par_err, pkt};
    end
  end

  // ------------------------------------------------------------------------
  // FIFO pointers and occupancy. Depth is a power of two so the pointers
  // wrap naturally. Simultaneous push and pop leave the level unchanged; a
  // pop while empty is ignored because pop is gated by a non-zero level.
  // ------------------------------------------------------------------------
  assign pop = (level != '0) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // First-word-fall-through head. Outputs read as zero while empty so that
  // everything is 0 straight out of reset.
  // ------------------------------------------------------------------------
  always_comb begin
    head           = mem[rd_ptr];
    out_valid      = (level != '0);
    out_data       = out_valid ? head[WIDTH-1:0] : '0;
    out_parity_err = out_valid & head[WIDTH];
    fifo_level     = level;
  end

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // ------------------------------------------------------------------------
  // Tallies. A clear takes priority over any increment in the same cycle.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      cnt_data       <= '0;
      cnt_cfg_wr     <= '0;
      cnt_cfg_rd     <= '0;
      cnt_bad_decl   <= '0;
      cnt_parity_err <= '0;
      cnt_filtered   <= '0;
    end else begin
      if (inc_data) begin
        cnt_data <= sat_inc(cnt_data);
      end
      if (inc_cfg_wr) begin
        cnt_cfg_wr <= sat_inc(cnt_cfg_wr);
      end
      if (inc_cfg_rd) begin
        cnt_cfg_rd <= sat_inc(cnt_cfg_rd);
      end
      if (inc_bad_decl) begin
        cnt_bad_decl <= sat_inc(cnt_bad_decl);
      end
      if (inc_parity_err) begin
        cnt_parity_err <= sat_inc(cnt_parity_err);
      end
      if (inc_filtered) begin
        cnt_filtered <= sat_inc(cnt_filtered);
      end
    end
  end

endmodule

// File: tb/tb_larpix_rx_packet_sorter.sv
// ---------------------------------------------------------------------------
// tb_larpix_rx_packet_sorter
//
// Directed bench for larpix_rx_packet_sorter. A small behavioural stand-in
// for uart_rx_fpga feeds queued words through the rx_empty / uld_rx_data
// handshake. Tally width is reduced to 4 bits so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_larpix_rx_packet_sorter;

  localparam int FD = 16;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [63:0]   rx_data;
  logic          rx_empty;
  logic          uld_rx_data;
  logic          filter_en;
  logic [7:0]    chip_id_filter;
  logic          cnt_clear;
  logic [63:0]   out_data;
  logic          out_parity_err;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    fifo_level;
  logic [CW-1:0] cnt_data;
  logic [CW-1:0] cnt_cfg_wr;
  logic [CW-1:0] cnt_cfg_rd;
  logic [CW-1:0] cnt_bad_decl;
  logic [CW-1:0] cnt_parity_err;
  logic [CW-1:0] cnt_filtered;

  int checks = 0;
  int errors = 0;
  int uld_count = 0;
  int uld_double = 0;
  logic [63:0] uart_q[$];

  // Hand-computed packets (bit63 = odd parity over bits 62:0).
  // P1: chip 0x10, data, good parity.
  localparam logic [63:0] P1 = 64'h8000_0000_0000_0041;
  // P2: chip 0x22, config read, payload ABCD, parity bit flipped.
  localparam logic [63:0] P2 = 64'h0000_ABCD_0000_008B;
  // PA: chip 0x1F, config write, good parity.
  localparam logic [63:0] PA = 64'h8000_0000_0000_007E;
  // PB: chip 0x00, data, good parity.
  localparam logic [63:0] PB = 64'h0000_0000_0000_0001;
  // PD: chip 0x10, declare 0, good parity; PDX same with bad parity.
  localparam logic [63:0] PD  = 64'h0000_0000_0000_0040;
  localparam logic [63:0] PDX = 64'h8000_0000_0000_0040;

  larpix_rx_packet_sorter #(
    .WIDTH(64),
    .FIFO_DEPTH(FD),
    .CNT_WIDTH(CW),
    .GLOBAL_ID(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_empty(rx_empty),
    .uld_rx_data(uld_rx_data),
    .filter_en(filter_en),
    .chip_id_filter(chip_id_filter),
    .cnt_clear(cnt_clear),
    .out_data(out_data),
    .out_parity_err(out_parity_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_level(fifo_level),
    .cnt_data(cnt_data),
    .cnt_cfg_wr(cnt_cfg_wr),
    .cnt_cfg_rd(cnt_cfg_rd),
    .cnt_bad_decl(cnt_bad_decl),
    .cnt_parity_err(cnt_parity_err),
    .cnt_filtered(cnt_filtered)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // UART stand-in: after an unload the empty flag rises and the next queued
  // word appears a few cycles later. Also records unload pulse statistics.
  initial begin
    int   gap;
    logic prev_uld;
    gap      = 0;
    prev_uld = 1'b0;
    rx_empty = 1'b1;
    rx_data  = '0;
    forever begin
      @(negedge clk);
      if (uld_rx_data) begin
        uld_count++;
        if (prev_uld) uld_double++;
        rx_empty = 1'b1;
        gap      = 3;
      end else if (rx_empty && gap > 0) begin
        gap--;
      end else if (rx_empty && uart_q.size() > 0) begin
        rx_data  = uart_q.pop_front();
        rx_empty = 1'b0;
      end
      prev_uld = uld_rx_data;
    end
  end

  // Sample point: just after the falling edge, well away from posedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] word);
    uart_q.push_back(word);
  endtask

  // Wait for the UART to present a word; lands in the cycle rx_empty falls.
  task automatic waitRxFall(input string tag);
    int n = 0;
    while (rx_empty !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rx_fall"}, 65'(rx_empty), 65'(0));
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 65'(out_valid), 65'(1));
  endtask

  // Check the head of the FIFO and pop it.
  task automatic popCheck(input string tag, input logic [63:0] exp_data,
                          input logic exp_perr);
    waitValid(tag);
    checkOutput({tag, "_data"}, 65'(out_data), 65'(exp_data));
    checkOutput({tag, "_perr"}, 65'(out_parity_err), 65'(exp_perr));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [63:0] makePkt(input logic [7:0] chip,
                                          input logic [1:0] decl,
                                          input logic [52:0] payload);
    logic [63:0] p;
    p[1:0]   = decl;
    p[9:2]   = chip;
    p[62:10] = payload;
    p[63]    = ~^p[62:0];
    return p;
  endfunction

  initial begin
    logic [63:0] burst [FD+3];
    int          uld_base;

    reset          = 1'b1;
    filter_en      = 1'b0;
    chip_id_filter = 8'h00;
    cnt_clear      = 1'b0;
    out_ready      = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    checkOutput("rst_valid", 65'(out_valid), 65'(0));
    checkOutput("rst_data", 65'(out_data), 65'(0));
    checkOutput("rst_uld", 65'(uld_rx_data), 65'(0));
    checkOutput("rst_level", 65'(fifo_level), 65'(0));
    checkOutput("rst_cnts", 65'({cnt_data, cnt_cfg_wr, cnt_cfg_rd,
                                 cnt_bad_decl, cnt_parity_err, cnt_filtered}), 65'(0));
    reset = 1'b0;
    tick();

    // ---------------- 1: data packet, latency ----------------
    applyStimulus(P1);
    waitRxFall("t1");
    checkOutput("t1_uld_c0", 65'(uld_rx_data), 65'(0));
    tick();
    checkOutput("t1_uld_c1", 65'(uld_rx_data), 65'(1));
    tick();
    checkOutput("t1_uld_c2", 65'(uld_rx_data), 65'(0));
    tick();
    checkOutput("t1_valid_c3", 65'(out_valid), 65'(0));
    tick();
    checkOutput("t1_valid_c4", 65'(out_valid), 65'(1));
    checkOutput("t1_data", 65'(out_data), 65'(P1));
    checkOutput("t1_perr", 65'(out_parity_err), 65'(0));
    checkOutput("t1_cnt_data", 65'(cnt_data), 65'(1));
    checkOutput("t1_level", 65'(fifo_level), 65'(1));
    checkOutput("t1_uld_count", 65'(uld_count), 65'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t1_level_after_pop", 65'(fifo_level), 65'(0));

    // ---------------- 2: config read with bad parity ----------------
    applyStimulus(P2);
    repeat (12) tick();
    checkOutput("t2_cnt_perr", 65'(cnt_parity_err), 65'(1));
    checkOutput("t2_cnt_cfg_rd", 65'(cnt_cfg_rd), 65'(1));
    popCheck("t2", P2, 1'b1);

    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;

    // ---------------- 3: chip ID filter ----------------
    filter_en      = 1'b1;
    chip_id_filter = 8'h1F;
    applyStimulus(PA);
    applyStimulus(PB);
    repeat (30) tick();
    checkOutput("t3_level", 65'(fifo_level), 65'(1));
    checkOutput("t3_cnt_filt", 65'(cnt_filtered), 65'(1));
    checkOutput("t3_cnt_cfg_wr", 65'(cnt_cfg_wr), 65'(1));
    checkOutput("t3_cnt_data", 65'(cnt_data), 65'(0));
    popCheck("t3_a", PA, 1'b0);
    chip_id_filter = 8'hFF;
    applyStimulus(PA);
    applyStimulus(PB);
    repeat (30) tick();
    checkOutput("t3g_level", 65'(fifo_level), 65'(2));
    checkOutput("t3g_cnt_filt", 65'(cnt_filtered), 65'(1));
    checkOutput("t3g_cnt_data", 65'(cnt_data), 65'(1));
    checkOutput("t3g_cnt_cfg_wr", 65'(cnt_cfg_wr), 65'(2));
    popCheck("t3g_a", PA, 1'b0);
    popCheck("t3g_b", PB, 1'b0);
    filter_en = 1'b0;

    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;

    // ---------------- 4: bad declare ----------------
    applyStimulus(PD);
    repeat (12) tick();
    checkOutput("t4_cnt_bad", 65'(cnt_bad_decl), 65'(1));
    checkOutput("t4_level", 65'(fifo_level), 65'(0));
    checkOutput("t4_others", 65'({cnt_data, cnt_cfg_wr, cnt_cfg_rd,
                                  cnt_parity_err, cnt_filtered}), 65'(0));
    applyStimulus(PDX);
    repeat (12) tick();
    checkOutput("t4x_cnt_bad", 65'(cnt_bad_decl), 65'(2));
    checkOutput("t4x_cnt_perr", 65'(cnt_parity_err), 65'(1));
    checkOutput("t4x_level", 65'(fifo_level), 65'(0));
    checkOutput("t4x_valid", 65'(out_valid), 65'(0));

    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;

    // ---------------- 5: backpressure and drain ----------------
    uld_base = uld_count;
    for (int i = 0; i < FD + 3; i++) begin
      burst[i] = makePkt(8'(i + 1), 2'b01, 53'(32'hA500_0000 + i));
      applyStimulus(burst[i]);
    end
    repeat (250) tick();
    checkOutput("t5_level_full", 65'(fifo_level), 65'(FD));
    checkOutput("t5_uld_count", 65'(uld_count - uld_base), 65'(FD));
    checkOutput("t5_cnt_sat", 65'(cnt_data), 65'(15));
    repeat (20) tick();
    checkOutput("t5_uld_held", 65'(uld_count - uld_base), 65'(FD));
    checkOutput("t5_uld_low", 65'(uld_rx_data), 65'(0));
    checkOutput("t5_word_waiting", 65'(rx_empty), 65'(0));
    for (int i = 0; i < FD + 3; i++) begin
      popCheck($sformatf("t5_pop%0d", i), burst[i], 1'b0);
    end
    repeat (5) tick();
    checkOutput("t5_level_empty", 65'(fifo_level), 65'(0));
    checkOutput("t5_uld_total", 65'(uld_count - uld_base), 65'(FD + 3));
    checkOutput("t5_cnt_sat_end", 65'(cnt_data), 65'(15));

    // ---------------- 6: reset during CAPTURE ----------------
    applyStimulus(PA);
    repeat (12) tick();
    checkOutput("t6_pre_level", 65'(fifo_level), 65'(1));
    applyStimulus(P1);
    waitRxFall("t6");
    tick();
    checkOutput("t6_uld_c1", 65'(uld_rx_data), 65'(1));
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t6_rst_level", 65'(fifo_level), 65'(0));
    checkOutput("t6_rst_valid", 65'(out_valid), 65'(0));
    checkOutput("t6_rst_data", 65'(out_data), 65'(0));
    checkOutput("t6_rst_perr", 65'(out_parity_err), 65'(0));
    checkOutput("t6_rst_uld", 65'(uld_rx_data), 65'(0));
    checkOutput("t6_rst_cnts", 65'({cnt_data, cnt_cfg_wr, cnt_cfg_rd,
                                    cnt_bad_decl, cnt_parity_err, cnt_filtered}), 65'(0));
    reset = 1'b0;
    repeat (12) tick();
    checkOutput("t6_discarded", 65'(fifo_level), 65'(0));

    applyStimulus(P1);
    repeat (12) tick();
    checkOutput("t6_next_level", 65'(fifo_level), 65'(1));
    checkOutput("t6_next_data", 65'(out_data), 65'(P1));
    checkOutput("t6_next_cnt", 65'(cnt_data), 65'(1));

    // cnt_clear during the CLASSIFY cycle beats the increment.
    applyStimulus(PB);
    waitRxFall("t6c");
    repeat (3) tick();
    checkOutput("t6c_cnt_before", 65'(cnt_data), 65'(1));
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    checkOutput("t6c_cnt_cleared", 65'(cnt_data), 65'(0));
    checkOutput("t6c_level", 65'(fifo_level), 65'(2));
    popCheck("t6c_p1", P1, 1'b0);
    popCheck("t6c_pb", PB, 1'b0);

    checkOutput("uld_single_cycle", 65'(uld_double), 65'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
